packet_buffer_write_arbiter: RTL

//  Shares the single write port of the packet buffer RAM between two byte-stream writers.

---
 rtl/packet_buffer_write_arbiter_if.sv | 39 +++
 rtl/packet_buffer_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/packet_buffer_write_arbiter_if.sv
// Bundles the two requester streams, the registered RAM write port and the
// statistics signals of the packet buffer write arbiter.
// The master side is the requesters plus the RAM driver. The slave side is the arbiter.
interface packet_buffer_write_arbiter_if #(
  parameter int AW       = 11,
  parameter int WORD_LEN = 8
);

  logic                valid0;
  logic                valid1;
  logic [AW-1:0]       addr0;
  logic [AW-1:0]       addr1;
  logic [WORD_LEN-1:0] data0;
  logic [WORD_LEN-1:0] data1;
  logic                last0;
  logic                last1;
  logic                ready0;
  logic                ready1;

  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [WORD_LEN-1:0] ram_win;

  logic                clr_stats;
  logic [15:0]         wr_count0;
  logic [15:0]         wr_count1;
  logic                err_oor;

  modport master (
    output valid0, valid1, addr0, addr1, data0, data1, last0, last1, clr_stats,
    input  ready0, ready1, ram_we, ram_waddr, ram_win, wr_count0, wr_count1, err_oor
  );

  modport slave (
    input  valid0, valid1, addr0, addr1, data0, data1, last0, last1, clr_stats,
    output ready0, ready1, ram_we, ram_waddr, ram_win, wr_count0, wr_count1, err_oor
  );

endinterface

// File: rtl/packet_buffer_write_arbiter.sv
// Shares the packet buffer RAM write port between the UART stream (requester 0)
// and the Ethernet byte stream (requester 1).
// Each requester has a one-word holding register. Arbitration is round-robin,
// and an owner keeps the port for at most MAX_BURST consecutive words or until
// it grants a word marked last. The RAM strobe, address and data are registered.
// An accepted word therefore reaches ram_we two edges after it is accepted.
// Optional macro PB_ARB_FIXED_PRIO_EN: when it is defined, requester 1 always
// wins whenever its hold is full. In that mode burst length and last are
// ignored for preemption.
module packet_buffer_write_arbiter #(
  parameter  int RAM_SIZE  = 1522,
  parameter  int WORD_LEN  = 8,
  parameter  int MAX_BURST = 16,
  localparam int AW        = $clog2(RAM_SIZE)
) (
  input logic                          clk,
  input logic                          rst,
  packet_buffer_write_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [BW-1:0]       r_burstCnt;
  logic [BW-1:0]       w_burstNext;
  logic                r_rrPtr;
  logic                w_rrNext;

  logic                r_holdFull0;
  logic                r_holdFull1;
  logic [AW-1:0]       r_holdAddr0;
  logic [AW-1:0]       r_holdAddr1;
  logic [WORD_LEN-1:0] r_holdData0;
  logic [WORD_LEN-1:0] r_holdData1;
  logic                r_holdLast0;
  logic                r_holdLast1;

  logic                r_ramWe;
  logic [AW-1:0]       r_ramWaddr;
  logic [WORD_LEN-1:0] r_ramWin;
  logic [15:0]         r_wrCount0;
  logic [15:0]         r_wrCount1;
  logic                r_errOor;

  logic                w_anyFull;
  logic                w_owner;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_ready0;
  logic                w_ready1;
  logic                w_accept0;
  logic                w_accept1;
  logic [AW-1:0]       w_selAddr;
  logic [WORD_LEN-1:0] w_selData;
  logic                w_selLast;
  logic                w_selInRange;
  logic                w_write;

  // Pick the single hold served this cycle, using only registered hold flags and state
  always_comb begin
    w_anyFull = r_holdFull0 | r_holdFull1;
    w_owner   = 1'b0;
`ifdef PB_ARB_FIXED_PRIO_EN
    w_owner = r_holdFull1;
`else
    if (r_state == OWN0 && r_holdFull0) begin
      w_owner = 1'b0;
    end else if (r_state == OWN1 && r_holdFull1) begin
      w_owner = 1'b1;
    end else if (r_holdFull0 && r_holdFull1) begin
      w_owner = r_rrPtr;
    end else begin
      w_owner = r_holdFull1;
    end
`endif
    w_grant0 = w_anyFull && !w_owner;
    w_grant1 = w_anyFull && w_owner;
  end

  // Handshake, and mux of the granted word toward the RAM output register
  always_comb begin
    w_ready0     = !r_holdFull0 || w_grant0;
    w_ready1     = !r_holdFull1 || w_grant1;
    w_accept0    = bus.valid0 && w_ready0;
    w_accept1    = bus.valid1 && w_ready1;
    w_selAddr    = w_owner ? r_holdAddr1 : r_holdAddr0;
    w_selData    = w_owner ? r_holdData1 : r_holdData0;
    w_selLast    = w_owner ? r_holdLast1 : r_holdLast0;
    w_selInRange = (32'(w_selAddr) < 32'(RAM_SIZE));
    w_write      = w_anyFull && w_selInRange;
  end

  // Ownership, burst length and round-robin pointer for the next cycle
  always_comb begin
    state_t        ownerState;
    state_t        otherState;
    logic          otherFull;
    logic [BW-1:0] cntUsed;
    w_stateNext = r_state;
    w_burstNext = r_burstCnt;
    w_rrNext    = r_rrPtr;
    ownerState  = w_owner ? OWN1 : OWN0;
    otherState  = w_owner ? OWN0 : OWN1;
    otherFull   = w_owner ? r_holdFull0 : r_holdFull1;
    cntUsed     = (r_state == ownerState) ? r_burstCnt : '0;
`ifdef PB_ARB_FIXED_PRIO_EN
    w_burstNext = '0;
    w_stateNext = w_anyFull ? ownerState : IDLE;
`else
    if (w_anyFull) begin
      w_rrNext = ~w_owner;
      if (w_selLast || (cntUsed == BW'(MAX_BURST - 1))) begin
        w_stateNext = otherFull ? otherState : IDLE;
        w_burstNext = '0;
      end else begin
        w_stateNext = ownerState;
        w_burstNext = cntUsed + BW'(1);
      end
    end
`endif
  end

  // Arbiter state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_burstCnt <= '0;
      r_rrPtr    <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_burstCnt <= w_burstNext;
      r_rrPtr    <= w_rrNext;
    end
  end

  // Hold register of requester 0; a refill in the same cycle as its grant replaces the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdFull0 <= 1'b0;
      r_holdAddr0 <= '0;
      r_holdData0 <= '0;
      r_holdLast0 <= 1'b0;
    end else if (w_accept0) begin
      r_holdFull0 <= 1'b1;
      r_holdAddr0 <= bus.addr0;
      r_holdData0 <= bus.data0;
      r_holdLast0 <= bus.last0;
    end else if (w_grant0) begin
      r_holdFull0 <= 1'b0;
    end
  end

  // Hold register of requester 1; same behaviour as the requester 0 hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdFull1 <= 1'b0;
      r_holdAddr1 <= '0;
      r_holdData1 <= '0;
      r_holdLast1 <= 1'b0;
    end else if (w_accept1) begin
      r_holdFull1 <= 1'b1;
      r_holdAddr1 <= bus.addr1;
      r_holdData1 <= bus.data1;
      r_holdLast1 <= bus.last1;
    end else if (w_grant1) begin
      r_holdFull1 <= 1'b0;
    end
  end

  // Registered RAM write port; address and data keep their last written value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ramWe    <= 1'b0;
      r_ramWaddr <= '0;
      r_ramWin   <= '0;
    end else begin
      r_ramWe <= w_write;
      if (w_write) begin
        r_ramWaddr <= w_selAddr;
        r_ramWin   <= w_selData;
      end
    end
  end

  // Statistics: saturating write counters and sticky out-of-range flag, clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrCount0 <= '0;
      r_wrCount1 <= '0;
      r_errOor   <= 1'b0;
    end else if (bus.clr_stats) begin
      r_wrCount0 <= '0;
      r_wrCount1 <= '0;
      r_errOor   <= 1'b0;
    end else begin
      if (w_write && !w_owner && (r_wrCount0 != 16'hFFFF)) begin
        r_wrCount0 <= r_wrCount0 + 16'd1;
      end
      if (w_write && w_owner && (r_wrCount1 != 16'hFFFF)) begin
        r_wrCount1 <= r_wrCount1 + 16'd1;
      end
      if (w_anyFull && !w_selInRange) begin
        r_errOor <= 1'b1;
      end
    end
  end

  assign bus.ready0    = w_ready0;
  assign bus.ready1    = w_ready1;
  assign bus.ram_we    = r_ramWe;
  assign bus.ram_waddr = r_ramWaddr;
  assign bus.ram_win   = r_ramWin;
  assign bus.wr_count0 = r_wrCount0;
  assign bus.wr_count1 = r_wrCount1;
  assign bus.err_oor   = r_errOor;

endmodule
